// File: rtl/marker_centroid_sched.sv
// marker_centroid_sched
//   Per-frame centroid engine for the dual-laser marker path. Streamed pixels
//   are classified as red/green marker hits, and the column/row sums and hit
//   counts for each channel are accumulated. At frame end the totals are
//   snapshotted, and one restoring divider is shared across four divisions
//   (red X, red Y, green X, green Y). The centroids are then presented to the
//   game logic with a valid/ready handshake.
//
//   Optional feature macro: MARKER_TEMPORAL_AVG_EN
//     defined   -> reported coordinates are a 1/4-weight IIR of per-frame
//                  centroids; not-found frames hold the average.
//     undefined -> raw per-frame truncated quotients are reported.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   vsync                 start of frame; clears live accumulators
//   pix_valid, frame_pixel  one RGB444 pixel per valid cycle, raster order
//   red_x/red_y/red_found   red centroid and found flag
//   grn_x/grn_y/grn_found   green centroid and found flag
//   out_valid, out_ready  result handshake
//   busy                  FSM not idle
//   overrun               1-cycle pulse when a finished frame is dropped
module marker_centroid_sched #(
    parameter int          H_RES    = 320,
    parameter int          V_RES    = 240,
    parameter int          CNT_W    = 17,
    parameter int          SUM_W    = 25,
    parameter logic [11:0] RED_CODE = 12'h007,
    parameter logic [11:0] GRN_CODE = 12'h070,
    parameter int          MIN_PIX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        pix_valid,
    input  logic [11:0] frame_pixel,
    output logic [8:0]  red_x,
    output logic [7:0]  red_y,
    output logic        red_found,
    output logic [8:0]  grn_x,
    output logic [7:0]  grn_y,
    output logic        grn_found,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        overrun
);
    localparam int TOTAL = H_RES * V_RES;
    localparam int COL_W = $clog2(H_RES);
    localparam int ROW_W = $clog2(V_RES);
    localparam int IT_W  = $clog2(SUM_W);

    typedef enum logic [2:0] {IDLE, DIV_RX, DIV_RY, DIV_GX, DIV_GY, OUT} state_t;
    state_t state, state_nx;

    // live accumulators
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] pcnt;
    logic             done;     // frame complete, ignore pixels until vsync
    logic             fe;       // frame-end pulse, one cycle after last pixel
    logic [SUM_W-1:0] r_sx, r_sy, g_sx, g_sy;
    logic [CNT_W-1:0] r_cnt, g_cnt;

    // frame snapshot
    logic [SUM_W-1:0] sh_rsy, sh_gsx, sh_gsy;
    logic [CNT_W-1:0] sh_rc, sh_gc;

    // shared divider
    logic [SUM_W-1:0] div_q;    // dividend shifts out the top, quotient in the bottom
    logic [CNT_W-1:0] div_rem;
    logic [IT_W-1:0]  it;
    logic [8:0]       rx_q, gx_q;
    logic [7:0]       ry_q, gy_q;

    logic acc, latch, in_div, last_it, ld, ge;
    logic r_ok, g_ok, r_ok_live, g_ok_live;
    logic [SUM_W-1:0] ld_sum, q_nx;
    logic [CNT_W-1:0] divisor, rem_nx;
    logic [CNT_W:0]   rem_sh;

    assign acc       = pix_valid && !vsync && !done;
    assign latch     = fe && (state == IDLE);
    assign r_ok_live = r_cnt >= CNT_W'(MIN_PIX);
    assign g_ok_live = g_cnt >= CNT_W'(MIN_PIX);
    assign r_ok      = sh_rc >= CNT_W'(MIN_PIX);
    assign g_ok      = sh_gc >= CNT_W'(MIN_PIX);
    assign in_div    = (state == DIV_RX) || (state == DIV_RY) ||
                       (state == DIV_GX) || (state == DIV_GY);
    assign last_it   = in_div && (it == IT_W'(SUM_W - 1));

    // ---------------- accumulation (independent of FSM) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0; row <= '0; pcnt <= '0; done <= 1'b0; fe <= 1'b0;
            r_sx <= '0; r_sy <= '0; g_sx <= '0; g_sy <= '0;
            r_cnt <= '0; g_cnt <= '0;
        end else begin
            fe <= 1'b0;
            if (vsync) begin
                col <= '0; row <= '0; pcnt <= '0; done <= 1'b0;
            end else if (acc) begin
                pcnt <= pcnt + 1'b1;
                if (col == COL_W'(H_RES - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (pcnt == CNT_W'(TOTAL - 1)) begin
                    done <= 1'b1;
                    fe   <= 1'b1;
                end
            end
            // latch and acc never coincide: done is already set at frame end
            if (vsync || latch) begin
                r_sx <= '0; r_sy <= '0; g_sx <= '0; g_sy <= '0;
                r_cnt <= '0; g_cnt <= '0;
            end else if (acc) begin
                if (frame_pixel == RED_CODE) begin
                    r_sx  <= r_sx + SUM_W'(col);
                    r_sy  <= r_sy + SUM_W'(row);
                    r_cnt <= r_cnt + 1'b1;
                end
                if (frame_pixel == GRN_CODE) begin
                    g_sx  <= g_sx + SUM_W'(col);
                    g_sy  <= g_sy + SUM_W'(row);
                    g_cnt <= g_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Channels below MIN_PIX skip both of their DIV states entirely. Leaving
    // IDLE, the decision uses the live counts because the snapshot is being
    // taken on that same edge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (latch) state_nx = r_ok_live ? DIV_RX : (g_ok_live ? DIV_GX : OUT);
            DIV_RX: if (last_it) state_nx = DIV_RY;
            DIV_RY: if (last_it) state_nx = g_ok ? DIV_GX : OUT;
            DIV_GX: if (last_it) state_nx = DIV_GY;
            DIV_GY: if (last_it) state_nx = OUT;
            OUT:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // ---------------- divider ----------------
    // The dividend is loaded on the edge that enters each DIV state, so all
    // SUM_W cycles in the state are iterations and no extra load cycle is needed.
    assign ld = (state_nx != state) &&
                ((state_nx == DIV_RX) || (state_nx == DIV_RY) ||
                 (state_nx == DIV_GX) || (state_nx == DIV_GY));

    always_comb begin
        ld_sum = '0;
        case (state_nx)
            DIV_RX: ld_sum = r_sx;                               // only entered from IDLE
            DIV_RY: ld_sum = sh_rsy;
            DIV_GX: ld_sum = (state == IDLE) ? g_sx : sh_gsx;
            DIV_GY: ld_sum = sh_gsy;
            default: ld_sum = '0;
        endcase
    end

    assign divisor = ((state == DIV_RX) || (state == DIV_RY)) ? sh_rc : sh_gc;
    assign rem_sh  = {div_rem, div_q[SUM_W-1]};
    assign ge      = rem_sh >= {1'b0, divisor};
    assign rem_nx  = ge ? CNT_W'(rem_sh - {1'b0, divisor}) : CNT_W'(rem_sh);
    assign q_nx    = {div_q[SUM_W-2:0], ge};

`ifdef MARKER_TEMPORAL_AVG_EN
    logic r_seen, g_seen;

    // avg + ((cur - avg) >>> 2), evaluated with one signed guard bit
    function automatic logic [8:0] iir9(input logic [8:0] avg, input logic [8:0] cur);
        logic signed [9:0] d;
        d = $signed({1'b0, cur}) - $signed({1'b0, avg});
        return avg + 9'(d >>> 2);
    endfunction

    function automatic logic [7:0] iir8(input logic [7:0] avg, input logic [7:0] cur);
        logic signed [8:0] d;
        d = $signed({1'b0, cur}) - $signed({1'b0, avg});
        return avg + 8'(d >>> 2);
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_rsy <= '0; sh_gsx <= '0; sh_gsy <= '0; sh_rc <= '0; sh_gc <= '0;
            div_q <= '0; div_rem <= '0; it <= '0;
            rx_q <= '0; ry_q <= '0; gx_q <= '0; gy_q <= '0;
            red_x <= '0; red_y <= '0; red_found <= 1'b0;
            grn_x <= '0; grn_y <= '0; grn_found <= 1'b0;
            out_valid <= 1'b0; overrun <= 1'b0;
`ifdef MARKER_TEMPORAL_AVG_EN
            r_seen <= 1'b0; g_seen <= 1'b0;
`endif
        end else begin
            overrun <= fe && (state != IDLE);

            if (latch) begin
                // red X never comes from the snapshot (loaded straight from live)
                sh_rsy <= r_sy; sh_gsx <= g_sx; sh_gsy <= g_sy;
                sh_rc  <= r_cnt; sh_gc <= g_cnt;
                // skipped channels report 0
                rx_q <= '0; ry_q <= '0; gx_q <= '0; gy_q <= '0;
            end

            if (last_it) begin
                case (state)
                    DIV_RX: rx_q <= q_nx[8:0];
                    DIV_RY: ry_q <= q_nx[7:0];
                    DIV_GX: gx_q <= q_nx[8:0];
                    DIV_GY: gy_q <= q_nx[7:0];
                    default: ;
                endcase
            end

            if (ld) begin
                div_q <= ld_sum; div_rem <= '0; it <= '0;
            end else if (in_div) begin
                div_q <= q_nx; div_rem <= rem_nx; it <= it + 1'b1;
            end

            // OUT: first cycle publishes, then hold until the handshake
            if (state == OUT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    red_found <= r_ok;
                    grn_found <= g_ok;
`ifdef MARKER_TEMPORAL_AVG_EN
                    if (r_ok) begin
                        red_x  <= r_seen ? iir9(red_x, rx_q) : rx_q;
                        red_y  <= r_seen ? iir8(red_y, ry_q) : ry_q;
                        r_seen <= 1'b1;
                    end
                    if (g_ok) begin
                        grn_x  <= g_seen ? iir9(grn_x, gx_q) : gx_q;
                        grn_y  <= g_seen ? iir8(grn_y, gy_q) : gy_q;
                        g_seen <= 1'b1;
                    end
`else
                    red_x <= rx_q; red_y <= ry_q;
                    grn_x <= gx_q; grn_y <= gy_q;
`endif
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
